// File: rtl/dsp_mul_share_arbiter.sv
// Round-robin arbiter time-sharing one pipelined DSP multiplier between NUM_REQ requesters.
// A tag pipeline matched to the DSP latency routes each result back to its issuer.
module dsp_mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW_X    = 27,
    parameter int DW_Y    = 27,
    parameter int DW_R    = 54,
    parameter int LATENCY = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hold_in,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    input  logic [NUM_REQ*DW_X-1:0]         req_x_in,
    input  logic [NUM_REQ*DW_Y-1:0]         req_y_in,
    input  logic [NUM_REQ-1:0]              req_negate_in,
    output logic [DW_X-1:0]                 op_x_out,
    output logic [DW_Y-1:0]                 op_y_out,
    output logic                            op_negate_out,
    output logic                            op_valid_out,
    input  logic [DW_R-1:0]                 op_result_in,
    output logic [NUM_REQ-1:0]              rsp_valid_out,
    output logic [DW_R-1:0]                 rsp_result_out,
    output logic [$clog2(LATENCY+3)-1:0]    inflight_count_out,
    output logic                            idle_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LATENCY+3);
    localparam logic [CW-1:0] CNT_MAX = CW'(LATENCY + 2);

    logic [IW-1:0]               ptr_q, ptr_d;
    logic                        gnt_found;
    logic [IW-1:0]               gnt_idx;
    logic [IW-1:0]               cand;

    logic [DW_X-1:0]             op_x_q, op_x_d;
    logic [DW_Y-1:0]             op_y_q, op_y_d;
    logic                        op_neg_q, op_neg_d;
    logic                        op_valid_q, op_valid_d;
    logic [IW-1:0]               op_idx_q, op_idx_d;

    logic [LATENCY-1:0]          tag_v_q, tag_v_d;
    logic [LATENCY-1:0][IW-1:0]  tag_idx_q, tag_idx_d;

    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [DW_R-1:0]             rsp_result_q, rsp_result_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    // First valid requester scanning upward from ptr; reset and hold suppress any grant.
    always_comb begin
        gnt_found     = 1'b0;
        gnt_idx       = '0;
        cand          = '0;
        req_ready_out = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid_in[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (hold_in || !rst_n) begin
            gnt_found = 1'b0;
        end
        if (gnt_found) begin
            req_ready_out[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        op_neg_d   = op_neg_q;
        op_idx_d   = op_idx_q;
        op_valid_d = gnt_found;
        if (gnt_found) begin
            ptr_d    = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IW'(1);
            op_x_d   = req_x_in[32'(gnt_idx)*DW_X +: DW_X];
            op_y_d   = req_y_in[32'(gnt_idx)*DW_Y +: DW_Y];
            op_neg_d = req_negate_in[gnt_idx];
            op_idx_d = gnt_idx;
        end

        tag_v_d      = tag_v_q;
        tag_idx_d    = tag_idx_q;
        tag_v_d[0]   = op_valid_q;
        tag_idx_d[0] = op_idx_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end

        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        if (tag_v_q[LATENCY-1]) begin
            rsp_valid_d[tag_idx_q[LATENCY-1]] = 1'b1;
            rsp_result_d = op_result_in;
        end

        case ({gnt_found, |rsp_valid_q})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            op_x_q       <= '0;
            op_y_q       <= '0;
            op_neg_q     <= 1'b0;
            op_valid_q   <= 1'b0;
            op_idx_q     <= '0;
            tag_v_q      <= '0;
            tag_idx_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            cnt_q        <= '0;
        end else begin
            ptr_q        <= ptr_d;
            op_x_q       <= op_x_d;
            op_y_q       <= op_y_d;
            op_neg_q     <= op_neg_d;
            op_valid_q   <= op_valid_d;
            op_idx_q     <= op_idx_d;
            tag_v_q      <= tag_v_d;
            tag_idx_q    <= tag_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            cnt_q        <= cnt_d;
        end
    end

    assign op_x_out           = op_x_q;
    assign op_y_out           = op_y_q;
    assign op_negate_out      = op_neg_q;
    assign op_valid_out       = op_valid_q;
    assign rsp_valid_out      = rsp_valid_q;
    assign rsp_result_out     = rsp_result_q;
    assign inflight_count_out = cnt_q;
    assign idle_out           = (cnt_q == '0);

    // An accept-to-response window spans LATENCY+2 cycles, so more in flight means a broken pipeline.
    a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_MAX)
        else $error("inflight count exceeded LATENCY+2");

endmodule

// File: tb/tb_dsp_mul_share_arbiter.sv
// Scoreboard bench: a tracker models round-robin grants and queues expected responses;
// a separate monitor pops and checks each response, plus in-flight count and idle.
module tb_dsp_mul_share_arbiter;

    localparam int N  = 4;
    localparam int DX = 27;
    localparam int DY = 27;
    localparam int DR = 54;
    localparam int L  = 3;
    localparam int CW = $clog2(L+3);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold_in;
    logic [N-1:0]      req_valid_in;
    logic [N-1:0]      req_ready_out;
    logic [N*DX-1:0]   req_x_in;
    logic [N*DY-1:0]   req_y_in;
    logic [N-1:0]      req_negate_in;
    logic [DX-1:0]     op_x_out;
    logic [DY-1:0]     op_y_out;
    logic              op_negate_out;
    logic              op_valid_out;
    logic [DR-1:0]     op_result_in;
    logic [N-1:0]      rsp_valid_out;
    logic [DR-1:0]     rsp_result_out;
    logic [CW-1:0]     inflight_count_out;
    logic              idle_out;

    dsp_mul_share_arbiter #(
        .NUM_REQ(N), .DW_X(DX), .DW_Y(DY), .DW_R(DR), .LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold_in(hold_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_x_in(req_x_in), .req_y_in(req_y_in), .req_negate_in(req_negate_in),
        .op_x_out(op_x_out), .op_y_out(op_y_out), .op_negate_out(op_negate_out),
        .op_valid_out(op_valid_out), .op_result_in(op_result_in),
        .rsp_valid_out(rsp_valid_out), .rsp_result_out(rsp_result_out),
        .inflight_count_out(inflight_count_out), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DR-1:0] prod(input logic [DX-1:0] x, input logic [DY-1:0] y,
                                           input logic n);
        logic signed [DR-1:0] p;
        p = $signed(x) * $signed(y);
        if (n) p = -p;
        return p;
    endfunction

    // Fixed-latency multiplier standing in for the DSP; it is never reset.
    logic [DR-1:0] dsp_pipe [L];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) dsp_pipe[i] <= dsp_pipe[i-1];
        dsp_pipe[0] <= prod(op_x_out, op_y_out, op_negate_out);
    end
    assign op_result_in = dsp_pipe[L-1];

    typedef struct {
        int            idx;
        logic [DR-1:0] res;
        int            due;
    } exp_t;
    exp_t q[$];
    exp_t me;

    // Monitor: response order, destination, value and arrival cycle.
    always @(negedge clk) begin
        chk("inflight", 64'(inflight_count_out), 64'(q.size()));
        chk("idle", 64'(idle_out), 64'(q.size() == 0));
        if (rsp_valid_out != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid_out), 64'(0));
            end else begin
                me = q.pop_front();
                chk("rsp_dest", 64'(rsp_valid_out), 64'(1) << me.idx);
                chk("rsp_result", 64'(rsp_result_out), 64'(me.res));
                chk("rsp_cycle", 64'(cyc), 64'(me.due));
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            chk("rsp_missing", 64'(rsp_valid_out), 64'(1) << q[0].idx);
            void'(q.pop_front());
        end
    end

    // Tracker: reference round-robin choice, issue register contents, scoreboard push.
    int            mptr = 0;
    bit            exp_opv = 1'b0;
    logic [DX-1:0] lx = '0;
    logic [DY-1:0] ly = '0;
    logic          ln = 1'b0;
    int            g;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            mptr = 0; exp_opv = 1'b0; lx = '0; ly = '0; ln = 1'b0;
        end
        chk("op_valid", 64'(op_valid_out), 64'(exp_opv));
        chk("op_x", 64'(op_x_out), 64'(lx));
        chk("op_y", 64'(op_y_out), 64'(ly));
        chk("op_negate", 64'(op_negate_out), 64'(ln));
        g = -1;
        if (rst_n && !hold_in) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid_in[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        chk("grant", 64'(req_ready_out), (g < 0) ? 64'(0) : (64'(1) << g));
        if (g >= 0) begin
            lx = req_x_in[g*DX +: DX];
            ly = req_y_in[g*DY +: DY];
            ln = req_negate_in[g];
            q.push_back('{idx: g, res: prod(lx, ly, ln), due: cyc + L + 2});
            exp_opv = 1'b1;
            mptr = (g + 1) % N;
        end else begin
            exp_opv = 1'b0;
        end
    end

    logic [N-1:0] fired;

    task automatic tick();
        @(negedge clk);
        fired = req_valid_in & req_ready_out;
        @(posedge clk);
        #1;
        req_valid_in = req_valid_in & ~fired;
    endtask

    task automatic load(input int i, input logic [DX-1:0] x, input logic [DY-1:0] y,
                        input logic n);
        req_valid_in[i]        = 1'b1;
        req_x_in[i*DX +: DX]   = x;
        req_y_in[i*DY +: DY]   = y;
        req_negate_in[i]       = n;
    endtask

    task automatic run_cont(input logic [N-1:0] mask, input int cycles);
        repeat (cycles) begin
            for (int i = 0; i < N; i++) begin
                if (mask[i] && !req_valid_in[i])
                    load(i, DX'($urandom()), DY'($urandom()), 1'($urandom_range(1)));
            end
            tick();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) tick();
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; hold_in = 1'b0; req_valid_in = '0;
        req_x_in = '0; req_y_in = '0; req_negate_in = '0;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready_out), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_out), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result_out), 64'(0));
        chk("rst_idle", 64'(idle_out), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single request from requester 2: 3*5
        load(2, DX'(3), DY'(5), 1'b0);
        tick();
        drain();

        // all requesters continuously valid
        run_cont('1, 12);
        req_valid_in = '0;
        drain();

        // move pointer to 2, then requesters 1 and 3 contend
        load(1, DX'(11), DY'(13), 1'b0);
        tick();
        run_cont(4'b1010, 3);
        req_valid_in = '0;
        drain();

        // negate path: -7 * 6 negated
        load(0, DX'(-7), DY'(6), 1'b1);
        tick();
        drain();

        // hold while everybody waits, with responses still draining
        run_cont('1, 2);
        hold_in = 1'b1;
        run_cont('1, 4);
        hold_in = 1'b0;
        run_cont('1, 6);
        req_valid_in = '0;
        drain();

        // reset with three operations in flight
        run_cont('1, 3);
        chk("pre_reset_inflight", 64'(q.size()), 64'(3));
        rst_n = 1'b0;
        q.delete();
        req_valid_in = '0;
        @(negedge clk);
        chk("reset_op_valid", 64'(op_valid_out), 64'(0));
        chk("reset_op_x", 64'(op_x_out), 64'(0));
        chk("reset_count", 64'(inflight_count_out), 64'(0));
        chk("reset_idle", 64'(idle_out), 64'(1));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        load(2, DX'(3), DY'(5), 1'b0);
        tick();
        drain();

        // randomized traffic with sporadic hold
        repeat (300) begin
            hold_in = ($urandom_range(7) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid_in[i] && $urandom_range(1) == 1)
                    load(i, DX'($urandom()), DY'($urandom()), 1'($urandom_range(1)));
            end
            tick();
        end
        hold_in = 1'b0;
        req_valid_in = '0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
